trig_coax_tx: RTL and testbench



---
 rtl/trig_coax_pkg.sv | 14 +
 rtl/trig_coax_lane.sv | 36 +++
 rtl/trig_coax_tx.sv | 142 ++++++++++++++
 tb/tb_trig_coax_tx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/trig_coax_pkg.sv
// Shared widths and FSM state encoding for the coax trigger transmitter.
package trig_coax_pkg;

   localparam int unsigned PH_W   = 2;
   localparam int unsigned DROP_W = 16;

   typedef logic [1:0] state_t;

   localparam state_t StIdle    = 2'd0;
   localparam state_t StCalWait = 2'd1;
   localparam state_t StCalSend = 2'd2;
   localparam state_t StCalDone = 2'd3;

endpackage

// File: rtl/trig_coax_lane.sv
// One coax lane: pending-request flag plus the registered coax drive.
module trig_coax_lane (
   input  logic clk_adc,
   input  logic rst,
   input  logic slot,
   input  logic force_zero,
   input  logic force_pulse,
   input  logic trig_req,
   output logic coax_out
);

   logic pend_q;
   logic coax_q;

   always_ff @(posedge clk_adc) begin
      if (rst) begin
         pend_q <= 1'b0;
         coax_q <= 1'b0;
      end else if (force_pulse) begin
         pend_q <= 1'b0;
         coax_q <= 1'b1;
      end else if (force_zero) begin
         pend_q <= 1'b0;
         coax_q <= 1'b0;
      end else if (slot) begin
         pend_q <= 1'b0;
         coax_q <= pend_q | trig_req;
      end else begin
         pend_q <= pend_q | trig_req;
         coax_q <= 1'b0;
      end
   end

   assign coax_out = coax_q;

endmodule

// File: rtl/trig_coax_tx.sv
// Coax trigger transmitter: slot-aligned trigger pulses in normal operation,
// fixed-phase sync bursts on all lanes during the calibration window.
module trig_coax_tx
   import trig_coax_pkg::*;
#(
   parameter int unsigned NLANE       = 8,
   parameter int unsigned PHASE       = 0,
   parameter int unsigned SYNC_WAIT   = 250,
   parameter int unsigned SYNC_PULSES = 54
) (
   input  logic              clk_adc,
   input  logic              rst,
   input  logic              calib_window,
   input  logic [NLANE-1:0]  trig_req,
   input  logic              clr_drop,
   output logic [NLANE-1:0]  coax_out,
   output logic              cal_ok,
   output logic              busy,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int unsigned WCNT_W = $clog2(SYNC_WAIT + 1);

   if (PHASE > 3) begin : g_phase_chk
      $error("PHASE must be in 0..3");
   end
   if (SYNC_PULSES > 255 || SYNC_PULSES == 0) begin : g_pulses_chk
      $error("SYNC_PULSES must be in 1..255");
   end

   logic [PH_W-1:0]   ph_q;
   logic              win_q;
   state_t            state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [7:0]        pcnt_q, pcnt_d, pcnt_inc;
   logic              cal_ok_q, cal_ok_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic slot, rise, fall;
   logic force_zero, force_pulse;

   assign slot     = (ph_q == PH_W'(PHASE));
   assign rise     = calib_window & ~win_q;
   assign fall     = ~calib_window & win_q;
   assign pcnt_inc = pcnt_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      pcnt_d      = pcnt_q;
      cal_ok_d    = cal_ok_q;
      force_zero  = 1'b1;
      force_pulse = 1'b0;
      unique case (state_q)
         StIdle: begin
            // A rise wins over a same-cycle request; force_zero drops pend too.
            if (rise) begin
               state_d  = StCalWait;
               wcnt_d   = '0;
               cal_ok_d = 1'b0;
            end else begin
               force_zero = 1'b0;
            end
         end
         StCalWait: begin
            if (fall) begin
               state_d = StIdle;
            end else if (wcnt_q == WCNT_W'(SYNC_WAIT - 1)) begin
               state_d = StCalSend;
               pcnt_d  = '0;
            end else begin
               wcnt_d = wcnt_q + WCNT_W'(1);
            end
         end
         StCalSend: begin
            if (fall) begin
               state_d = StIdle;
            end else if (slot) begin
               force_pulse = 1'b1;
               force_zero  = 1'b0;
               pcnt_d      = pcnt_inc;
               if (pcnt_inc == 8'(SYNC_PULSES)) begin
                  state_d  = StCalDone;
                  cal_ok_d = 1'b1;
               end
            end
         end
         StCalDone: begin
            if (fall) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      drop_d = drop_q;
      if (clr_drop) begin
         drop_d = '0;
      end else if (state_q != StIdle && |trig_req && drop_q != '1) begin
         drop_d = drop_q + DROP_W'(1);
      end
   end

   always_ff @(posedge clk_adc) begin
      if (rst) begin
         ph_q     <= '0;
         win_q    <= 1'b0;
         state_q  <= StIdle;
         wcnt_q   <= '0;
         pcnt_q   <= '0;
         cal_ok_q <= 1'b0;
         drop_q   <= '0;
      end else begin
         ph_q     <= ph_q + PH_W'(1);
         win_q    <= calib_window;
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         pcnt_q   <= pcnt_d;
         cal_ok_q <= cal_ok_d;
         drop_q   <= drop_d;
      end
   end

   for (genvar i = 0; i < NLANE; i++) begin : g_lane
      trig_coax_lane u_lane (
         .clk_adc     (clk_adc),
         .rst         (rst),
         .slot        (slot),
         .force_zero  (force_zero),
         .force_pulse (force_pulse),
         .trig_req    (trig_req[i]),
         .coax_out    (coax_out[i])
      );
   end

   assign busy     = (state_q != StIdle);
   assign cal_ok   = cal_ok_q;
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_trig_coax_tx.sv
// Directed bench for trig_coax_tx: vector table for reset/slot alignment,
// hand sequences for calibration, abort, drops, collision and saturation.
module tb_trig_coax_tx;

   localparam int NLANE       = 8;
   localparam int PHASE       = 0;
   localparam int SYNC_WAIT   = 250;
   localparam int SYNC_PULSES = 54;

   logic             clk_adc = 1'b0;
   logic             rst;
   logic             calib_window;
   logic [NLANE-1:0] trig_req;
   logic             clr_drop;
   logic [NLANE-1:0] coax_out;
   logic             cal_ok;
   logic             busy;
   logic [15:0]      drop_cnt;

   int          total = 0;
   int          bad   = 0;
   int          ph_m  = 0;
   logic [15:0] exp_drop = 16'h0;

   always #5 clk_adc = ~clk_adc;

   trig_coax_tx #(
      .NLANE       (NLANE),
      .PHASE       (PHASE),
      .SYNC_WAIT   (SYNC_WAIT),
      .SYNC_PULSES (SYNC_PULSES)
   ) dut (
      .clk_adc      (clk_adc),
      .rst          (rst),
      .calib_window (calib_window),
      .trig_req     (trig_req),
      .clr_drop     (clr_drop),
      .coax_out     (coax_out),
      .cal_ok       (cal_ok),
      .busy         (busy),
      .drop_cnt     (drop_cnt)
   );

   typedef struct {
      logic       rst;
      logic [7:0] trig;
      logic [7:0] coax;
      logic       busy;
      logic       cal_ok;
   } vec_t;

   vec_t vt[13];

   // ph_m tracks the phase of the cycle that follows the edge just taken.
   task automatic step();
      @(posedge clk_adc);
      ph_m = rst ? 0 : (ph_m + 1) % 4;
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic cal_run(input int win_len, input int drop_from, input int drop_len,
                          input logic [7:0] rise_req, input int clr_at);
      int         np;
      logic       pulse;
      logic [7:0] req;
      np = 0;
      for (int k = 1; k <= win_len + 8; k++) begin
         calib_window = (k <= win_len);
         req = (drop_len > 0 && k >= drop_from && k < drop_from + drop_len) ? 8'h01 : 8'h00;
         if (k == 1) req = req | rise_req;
         trig_req = req;
         clr_drop = (k == clr_at);
         step();
         // Sync pulses land after the quiet period, one per slot, visible at ph==PHASE+1.
         pulse = (k >= SYNC_WAIT + 2) && (k <= win_len) && (ph_m == (PHASE + 1) % 4)
                 && (np < SYNC_PULSES);
         if (pulse) np++;
         if (k == clr_at) exp_drop = 16'h0;
         else if (req != 8'h00 && k >= 2 && k <= win_len + 1 && exp_drop != 16'hFFFF)
            exp_drop = exp_drop + 16'h1;
         chk("cal_coax", 32'(coax_out), 32'(pulse ? 8'hFF : 8'h00));
         chk("cal_busy", 32'(busy), 32'(k <= win_len));
         chk("cal_ok", 32'(cal_ok), 32'(np >= SYNC_PULSES));
         chk("cal_drop", 32'(drop_cnt), 32'(exp_drop));
      end
      trig_req     = '0;
      clr_drop     = 1'b0;
      calib_window = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      calib_window = 1'b0;
      clr_drop     = 1'b0;
      trig_req     = '0;

      // rst, trig, coax, busy, cal_ok
      vt[0]  = '{1'b1, 8'hFF, 8'h00, 1'b0, 1'b0};
      vt[1]  = '{1'b1, 8'hFF, 8'h00, 1'b0, 1'b0};
      vt[2]  = '{1'b1, 8'hFF, 8'h00, 1'b0, 1'b0};
      vt[3]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      vt[4]  = '{1'b0, 8'h04, 8'h00, 1'b0, 1'b0};
      vt[5]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      vt[6]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      vt[7]  = '{1'b0, 8'h00, 8'h04, 1'b0, 1'b0};
      vt[8]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      vt[9]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      vt[10] = '{1'b0, 8'h80, 8'h00, 1'b0, 1'b0};
      vt[11] = '{1'b0, 8'h01, 8'h81, 1'b0, 1'b0};
      vt[12] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0};

      for (int i = 0; i < 13; i++) begin
         rst      = vt[i].rst;
         trig_req = vt[i].trig;
         step();
         chk("vec_coax", 32'(coax_out), 32'(vt[i].coax));
         chk("vec_busy", 32'(busy), 32'(vt[i].busy));
         chk("vec_cal_ok", 32'(cal_ok), 32'(vt[i].cal_ok));
         chk("vec_drop", 32'(drop_cnt), 32'h0);
      end
      trig_req = '0;

      // Full calibration burst.
      cal_run(655, 0, 0, 8'h00, 0);

      // Abort in the middle of the burst, then a normal trigger.
      cal_run(300, 0, 0, 8'h00, 0);
      while (ph_m != 2) step();
      trig_req = 8'h10;
      step();
      chk("post_abort_c0", 32'(coax_out), 32'h0);
      trig_req = '0;
      step();
      chk("post_abort_c1", 32'(coax_out), 32'h0);
      step();
      chk("post_abort_pulse", 32'(coax_out), 32'h10);
      chk("post_abort_cal_ok", 32'(cal_ok), 32'h0);
      chk("post_abort_busy", 32'(busy), 32'h0);

      // Drops during the burst, then clear.
      cal_run(655, 300, 10, 8'h00, 0);
      chk("drop_ten", 32'(drop_cnt), 32'd10);
      clr_drop = 1'b1;
      step();
      clr_drop = 1'b0;
      exp_drop = 16'h0;
      chk("drop_clr", 32'(drop_cnt), 32'h0);

      // Request colliding with the window rise.
      cal_run(655, 0, 0, 8'h01, 0);

      // Saturation at 0xFFFF, then clear winning over a same-cycle increment.
      cal_run(65560, 2, 65558, 8'h00, 65550);

      // Reset mid-burst.
      calib_window = 1'b1;
      trig_req     = 8'h01;
      for (int i = 0; i < 300; i++) step();
      chk("pre_rst_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      step();
      chk("rst_coax", 32'(coax_out), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_cal_ok", 32'(cal_ok), 32'h0);
      chk("rst_drop", 32'(drop_cnt), 32'h0);
      rst          = 1'b0;
      calib_window = 1'b0;
      trig_req     = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("after_rst_coax", 32'(coax_out), 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
